pic_priority_scheduler: RTL and testbench

- Interrupt-sequencing core of the 8259 PIC, downstream of the read/write command logic.
- Latches IR0-IR7 requests into IRR and resolves priority against IMR and ISR, with fixed or rotating priority.
- Raises INT and sequences the two-pulse 8086 INTA cycle that drives the vector onto the data bus.
- Executes OCW2 EOI and rotation commands and clears state on ICW1.

---
 rtl/pic_pkg.sv | 30 +++
 rtl/pic_priority_scheduler_if.sv | 12 +
 rtl/pic_priority_resolver.sv | 37 +++
 rtl/pic_priority_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_pic_priority_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 interrupt-sequencing core.
package pic_pkg;

    localparam int NUM_IR     = 8;
    localparam int LVL_W      = 3;
    localparam int VEC_BASE_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } pic_state_t;

    // OCW2 R/SL/EOI field encodings
    localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] CMD_NS_EOI       = 3'b001;
    localparam logic [2:0] CMD_S_EOI        = 3'b011;
    localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] CMD_ROT_NS       = 3'b101;
    localparam logic [2:0] CMD_SET_PRI      = 3'b110;
    localparam logic [2:0] CMD_ROT_S        = 3'b111;

    // Rank 0 is the highest priority, i.e. the level just after lowest.
    function automatic logic [LVL_W-1:0] pri_rank(input logic [LVL_W-1:0] lvl,
                                                  input logic [LVL_W-1:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_scheduler_if.sv
// CPU-side interrupt acknowledge / vector bus of the 8259 core.
interface pic_priority_scheduler_if;
    import pic_pkg::*;

    logic              intaN;
    logic              intOut;
    logic [NUM_IR-1:0] dataOut;
    logic              dataOutEn;

    modport master (output intaN, input intOut, dataOut, dataOutEn);
    modport slave  (input intaN, output intOut, dataOut, dataOutEn);
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority encoder: returns the highest-priority set
// bit of req, where priority starts at lowest_pri+1 and wraps.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] req,
    input  logic [LVL_W-1:0]  lowest_pri,
    output logic              valid,
    output logic [LVL_W-1:0]  level
);
    logic [LVL_W-1:0]  start;
    logic [NUM_IR-1:0] rot;
    logic [LVL_W-1:0]  offset;

    assign start = lowest_pri + 3'd1;

    // rot[0] is the request currently holding top priority
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IR; gi++) begin : g_rot
            assign rot[gi] = req[LVL_W'(gi) + start];
        end
    endgenerate

    always_comb begin
        valid  = 1'b0;
        offset = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid  = 1'b1;
                offset = LVL_W'(i);
            end
        end
    end

    assign level = offset + start;
endmodule

// File: rtl/pic_priority_scheduler.sv
// 8259 interrupt sequencing: IRR/ISR, priority resolution, INTA vector cycle.
// Optional macro PIC_SPURIOUS_IR7_EN: answer an unrequested INTA with the IR7 vector.
module pic_priority_scheduler
    import pic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [NUM_IR-1:0]     ir,
    input  logic [NUM_IR-1:0]     imr,
    input  logic                  ltim,
    input  logic [VEC_BASE_W-1:0] vecBase,
    input  logic                  aeoi,
    input  logic                  initStart,
    input  logic                  ocw2Strobe,
    input  logic [7:0]            ocw2,
    pic_priority_scheduler_if.slave cpu,
    output logic [NUM_IR-1:0]     irr,
    output logic [NUM_IR-1:0]     isr
);
    pic_state_t        state_reg, state_next;
    logic [LVL_W-1:0]  ack_lvl_reg, ack_lvl_next;
    logic              ack_valid_reg, ack_valid_next;
    logic [LVL_W-1:0]  lowest_pri_reg, lowest_pri_next;
    logic              rot_aeoi_reg, rot_aeoi_next;
    logic [NUM_IR-1:0] ir_prev_reg, ir_prev_next;
    logic [NUM_IR-1:0] irr_reg, irr_next;
    logic [NUM_IR-1:0] isr_reg, isr_next;
    logic              int_reg, int_next;
    logic [7:0]        dout_reg, dout_next;
    logic              den_reg, den_next;

    logic              pend_valid, svc_valid;
    logic [LVL_W-1:0]  pend_lvl, svc_lvl;
    logic [NUM_IR-1:0] ack_set, isr_clr;
    logic              ocw2_valid;
    logic [LVL_W-1:0]  ocw_lvl;

    pic_priority_resolver u_pend (
        .req        (irr_reg & ~imr),
        .lowest_pri (lowest_pri_reg),
        .valid      (pend_valid),
        .level      (pend_lvl)
    );

    pic_priority_resolver u_svc (
        .req        (isr_reg),
        .lowest_pri (lowest_pri_reg),
        .valid      (svc_valid),
        .level      (svc_lvl)
    );

    // D4:D3 = 00 is what distinguishes an OCW2 write from ICW1/OCW3
    assign ocw2_valid = ocw2Strobe && (ocw2[4:3] == 2'b00);
    assign ocw_lvl    = ocw2[2:0];

    always_comb begin
        state_next      = state_reg;
        ack_lvl_next    = ack_lvl_reg;
        ack_valid_next  = ack_valid_reg;
        lowest_pri_next = lowest_pri_reg;
        rot_aeoi_next   = rot_aeoi_reg;
        dout_next       = dout_reg;
        den_next        = den_reg;
        ack_set         = '0;
        isr_clr         = '0;

        case (state_reg)
            IDLE: begin
                if (!cpu.intaN) begin
                    if (pend_valid) begin
                        state_next     = ACK1;
                        ack_lvl_next   = pend_lvl;
                        ack_valid_next = 1'b1;
                        ack_set        = NUM_IR'(1) << pend_lvl;
                    end
`ifdef PIC_SPURIOUS_IR7_EN
                    else begin
                        state_next     = ACK1;
                        ack_lvl_next   = 3'd7;
                        ack_valid_next = 1'b0;
                    end
`else
                    else begin
                        state_next = IDLE;
                    end
`endif
                end
            end
            ACK1: if (cpu.intaN) state_next = GAP;
            GAP: begin
                if (!cpu.intaN) begin
                    state_next = ACK2;
                    dout_next  = {vecBase, ack_lvl_reg};
                    den_next   = 1'b1;
                end
            end
            ACK2: begin
                if (cpu.intaN) begin
                    state_next = IDLE;
                    den_next   = 1'b0;
                    // a spurious cycle never set an ISR bit, so AEOI has nothing to retire
                    if (aeoi && ack_valid_reg) begin
                        isr_clr = NUM_IR'(1) << ack_lvl_reg;
                        if (rot_aeoi_reg) lowest_pri_next = ack_lvl_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (ocw2_valid) begin
            case (ocw2[7:5])
                CMD_NS_EOI: if (svc_valid) isr_clr |= NUM_IR'(1) << svc_lvl;
                CMD_S_EOI:  isr_clr |= NUM_IR'(1) << ocw_lvl;
                CMD_ROT_NS: begin
                    if (svc_valid) begin
                        isr_clr |= NUM_IR'(1) << svc_lvl;
                        lowest_pri_next = svc_lvl;
                    end
                end
                CMD_ROT_S: begin
                    isr_clr |= NUM_IR'(1) << ocw_lvl;
                    lowest_pri_next = ocw_lvl;
                end
                CMD_SET_PRI:      lowest_pri_next = ocw_lvl;
                CMD_ROT_AEOI_SET: rot_aeoi_next = 1'b1;
                CMD_ROT_AEOI_CLR: rot_aeoi_next = 1'b0;
                default: ;
            endcase
        end

        ir_prev_next = ir;
        if (ltim) irr_next = ir & ~ack_set;
        else      irr_next = (irr_reg | (ir & ~ir_prev_reg)) & ir & ~ack_set;
        // the acknowledge set wins over any EOI clear of the same bit
        isr_next = (isr_reg & ~isr_clr) | ack_set;
        int_next = pend_valid
                && (!svc_valid || (pri_rank(pend_lvl, lowest_pri_reg) < pri_rank(svc_lvl, lowest_pri_reg)))
                && (state_reg == IDLE) && (state_next == IDLE);

        if (initStart) begin
            state_next      = IDLE;
            ack_lvl_next    = '0;
            ack_valid_next  = 1'b0;
            lowest_pri_next = 3'd7;
            rot_aeoi_next   = 1'b0;
            ir_prev_next    = '0;
            irr_next        = '0;
            isr_next        = '0;
            int_next        = 1'b0;
            dout_next       = '0;
            den_next        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg      <= IDLE;
            ack_lvl_reg    <= '0;
            ack_valid_reg  <= 1'b0;
            lowest_pri_reg <= 3'd7;
            rot_aeoi_reg   <= 1'b0;
            ir_prev_reg    <= '0;
            irr_reg        <= '0;
            isr_reg        <= '0;
            int_reg        <= 1'b0;
            dout_reg       <= '0;
            den_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ack_lvl_reg    <= ack_lvl_next;
            ack_valid_reg  <= ack_valid_next;
            lowest_pri_reg <= lowest_pri_next;
            rot_aeoi_reg   <= rot_aeoi_next;
            ir_prev_reg    <= ir_prev_next;
            irr_reg        <= irr_next;
            isr_reg        <= isr_next;
            int_reg        <= int_next;
            dout_reg       <= dout_next;
            den_reg        <= den_next;
        end
    end

    assign cpu.intOut    = int_reg;
    assign cpu.dataOut   = dout_reg;
    assign cpu.dataOutEn = den_reg;
    assign irr           = irr_reg;
    assign isr           = isr_reg;
endmodule

// File: tb/tb_pic_priority_scheduler.sv
// Directed bench for pic_priority_scheduler: cycle table plus INTA corner sequences.
module tb_pic_priority_scheduler;
    import pic_pkg::*;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] ir = '0, imr = '0, ocw2 = '0;
    logic       ltim = 1'b0, aeoi = 1'b0, initStart = 1'b0, ocw2Strobe = 1'b0;
    logic [4:0] vecBase = 5'h08;
    logic [7:0] irr, isr;

    int checks = 0;
    int errors = 0;

    pic_priority_scheduler_if cpu_if ();

    pic_priority_scheduler dut (
        .clk        (clk),
        .rstN       (rstN),
        .ir         (ir),
        .imr        (imr),
        .ltim       (ltim),
        .vecBase    (vecBase),
        .aeoi       (aeoi),
        .initStart  (initStart),
        .ocw2Strobe (ocw2Strobe),
        .ocw2       (ocw2),
        .cpu        (cpu_if),
        .irr        (irr),
        .isr        (isr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ir;
        logic [7:0] imr;
        logic       inta_n;
        logic       init;
        logic       stb;
        logic [7:0] ocw2;
        logic       aeoi;
        logic       ex_int;
        logic [7:0] ex_irr;
        logic [7:0] ex_isr;
        logic [7:0] ex_dout;
        logic       ex_den;
    } vec_t;

    localparam int NV = 53;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] ir_v, imr_v, input logic inta_v, init_v, stb_v,
                                input logic [7:0] ocw_v, input logic aeoi_v, input logic e_int,
                                input logic [7:0] e_irr, e_isr, e_dout, input logic e_den);
        vec_t v;
        v.ir = ir_v; v.imr = imr_v; v.inta_n = inta_v; v.init = init_v; v.stb = stb_v;
        v.ocw2 = ocw_v; v.aeoi = aeoi_v; v.ex_int = e_int; v.ex_irr = e_irr;
        v.ex_isr = e_isr; v.ex_dout = e_dout; v.ex_den = e_den;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] ir_v, imr_v, input logic inta_v, init_v, stb_v,
                        input logic [7:0] ocw_v, input logic aeoi_v);
        ir = ir_v; imr = imr_v; cpu_if.intaN = inta_v; initStart = init_v;
        ocw2Strobe = stb_v; ocw2 = ocw_v; aeoi = aeoi_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // edge mode, vecBase=08, fixed priority
        vecs[0]  = mk(8'h08,8'h00,1,0,0,8'h00,0, 0,8'h08,8'h00,8'h00,0);
        vecs[1]  = mk(8'h08,8'h00,1,0,0,8'h00,0, 1,8'h08,8'h00,8'h00,0);
        vecs[2]  = mk(8'h08,8'h00,0,0,0,8'h00,0, 0,8'h00,8'h08,8'h00,0);
        vecs[3]  = mk(8'h08,8'h00,1,0,0,8'h00,0, 0,8'h00,8'h08,8'h00,0);
        vecs[4]  = mk(8'h08,8'h00,0,0,0,8'h00,0, 0,8'h00,8'h08,8'h43,1);
        vecs[5]  = mk(8'h08,8'h00,1,0,0,8'h00,0, 0,8'h00,8'h08,8'h43,0);
        vecs[6]  = mk(8'h00,8'h00,1,0,0,8'h00,0, 0,8'h00,8'h08,8'h43,0);
        vecs[7]  = mk(8'h00,8'h00,1,0,1,8'h20,0, 0,8'h00,8'h00,8'h43,0);
        // IR0 masked, IR2 wins; NS EOI leaves masked IR0 pending
        vecs[8]  = mk(8'h05,8'h01,1,0,0,8'h00,0, 0,8'h05,8'h00,8'h43,0);
        vecs[9]  = mk(8'h05,8'h01,1,0,0,8'h00,0, 1,8'h05,8'h00,8'h43,0);
        vecs[10] = mk(8'h05,8'h01,0,0,0,8'h00,0, 0,8'h01,8'h04,8'h43,0);
        vecs[11] = mk(8'h05,8'h01,1,0,0,8'h00,0, 0,8'h01,8'h04,8'h43,0);
        vecs[12] = mk(8'h05,8'h01,0,0,0,8'h00,0, 0,8'h01,8'h04,8'h42,1);
        vecs[13] = mk(8'h05,8'h01,1,0,0,8'h00,0, 0,8'h01,8'h04,8'h42,0);
        vecs[14] = mk(8'h05,8'h01,1,0,1,8'h20,0, 0,8'h01,8'h00,8'h42,0);
        vecs[15] = mk(8'h05,8'h01,1,0,0,8'h00,0, 0,8'h01,8'h00,8'h42,0);
        // IR1 in service: IR4 blocked, IR0 nests
        vecs[16] = mk(8'h00,8'h01,1,0,0,8'h00,0, 0,8'h00,8'h00,8'h42,0);
        vecs[17] = mk(8'h02,8'h00,1,0,0,8'h00,0, 0,8'h02,8'h00,8'h42,0);
        vecs[18] = mk(8'h02,8'h00,1,0,0,8'h00,0, 1,8'h02,8'h00,8'h42,0);
        vecs[19] = mk(8'h02,8'h00,0,0,0,8'h00,0, 0,8'h00,8'h02,8'h42,0);
        vecs[20] = mk(8'h02,8'h00,1,0,0,8'h00,0, 0,8'h00,8'h02,8'h42,0);
        vecs[21] = mk(8'h02,8'h00,0,0,0,8'h00,0, 0,8'h00,8'h02,8'h41,1);
        vecs[22] = mk(8'h02,8'h00,1,0,0,8'h00,0, 0,8'h00,8'h02,8'h41,0);
        vecs[23] = mk(8'h12,8'h00,1,0,0,8'h00,0, 0,8'h10,8'h02,8'h41,0);
        vecs[24] = mk(8'h12,8'h00,1,0,0,8'h00,0, 0,8'h10,8'h02,8'h41,0);
        vecs[25] = mk(8'h13,8'h00,1,0,0,8'h00,0, 0,8'h11,8'h02,8'h41,0);
        vecs[26] = mk(8'h13,8'h00,1,0,0,8'h00,0, 1,8'h11,8'h02,8'h41,0);
        vecs[27] = mk(8'h00,8'h00,1,1,0,8'h00,0, 0,8'h00,8'h00,8'h00,0);
        // set priority L=4: IR5 before IR0
        vecs[28] = mk(8'h00,8'h00,1,0,1,8'hC4,0, 0,8'h00,8'h00,8'h00,0);
        vecs[29] = mk(8'h21,8'h00,1,0,0,8'h00,0, 0,8'h21,8'h00,8'h00,0);
        vecs[30] = mk(8'h21,8'h00,1,0,0,8'h00,0, 1,8'h21,8'h00,8'h00,0);
        vecs[31] = mk(8'h21,8'h00,0,0,0,8'h00,0, 0,8'h01,8'h20,8'h00,0);
        vecs[32] = mk(8'h21,8'h00,1,0,0,8'h00,0, 0,8'h01,8'h20,8'h00,0);
        vecs[33] = mk(8'h21,8'h00,0,0,0,8'h00,0, 0,8'h01,8'h20,8'h45,1);
        vecs[34] = mk(8'h21,8'h00,1,0,0,8'h00,0, 0,8'h01,8'h20,8'h45,0);
        vecs[35] = mk(8'h21,8'h00,1,0,1,8'h65,0, 0,8'h01,8'h00,8'h45,0);
        vecs[36] = mk(8'h21,8'h00,1,0,0,8'h00,0, 1,8'h01,8'h00,8'h45,0);
        vecs[37] = mk(8'h00,8'h00,1,1,0,8'h00,0, 0,8'h00,8'h00,8'h00,0);
        // AEOI with rotation: IR2 served, then IR3 outranks IR2
        vecs[38] = mk(8'h00,8'h00,1,0,1,8'h80,1, 0,8'h00,8'h00,8'h00,0);
        vecs[39] = mk(8'h04,8'h00,1,0,0,8'h00,1, 0,8'h04,8'h00,8'h00,0);
        vecs[40] = mk(8'h04,8'h00,1,0,0,8'h00,1, 1,8'h04,8'h00,8'h00,0);
        vecs[41] = mk(8'h04,8'h00,0,0,0,8'h00,1, 0,8'h00,8'h04,8'h00,0);
        vecs[42] = mk(8'h04,8'h00,1,0,0,8'h00,1, 0,8'h00,8'h04,8'h00,0);
        vecs[43] = mk(8'h04,8'h00,0,0,0,8'h00,1, 0,8'h00,8'h04,8'h42,1);
        vecs[44] = mk(8'h04,8'h00,1,0,0,8'h00,1, 0,8'h00,8'h00,8'h42,0);
        vecs[45] = mk(8'h00,8'h00,1,0,0,8'h00,1, 0,8'h00,8'h00,8'h42,0);
        vecs[46] = mk(8'h0C,8'h00,1,0,0,8'h00,1, 0,8'h0C,8'h00,8'h42,0);
        vecs[47] = mk(8'h0C,8'h00,1,0,0,8'h00,1, 1,8'h0C,8'h00,8'h42,0);
        vecs[48] = mk(8'h0C,8'h00,0,0,0,8'h00,1, 0,8'h04,8'h08,8'h42,0);
        vecs[49] = mk(8'h0C,8'h00,1,0,0,8'h00,1, 0,8'h04,8'h08,8'h42,0);
        vecs[50] = mk(8'h0C,8'h00,0,0,0,8'h00,1, 0,8'h04,8'h08,8'h43,1);
        vecs[51] = mk(8'h0C,8'h00,1,0,0,8'h00,1, 0,8'h04,8'h00,8'h43,0);
        vecs[52] = mk(8'h0C,8'h00,1,0,0,8'h00,1, 1,8'h04,8'h00,8'h43,0);

        cpu_if.intaN = 1'b1;
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset intOut", {7'b0, cpu_if.intOut}, 8'h00);
        chk("reset irr", irr, 8'h00);
        chk("reset isr", isr, 8'h00);
        chk("reset dataOut", cpu_if.dataOut, 8'h00);
        chk("reset dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h00);
        rstN = 1'b1;
        $display("reset released");

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].ir, vecs[i].imr, vecs[i].inta_n, vecs[i].init, vecs[i].stb,
                 vecs[i].ocw2, vecs[i].aeoi);
            $display("vec %0d: ir=%02h intaN=%0d -> int=%0d irr=%02h isr=%02h dout=%02h den=%0d",
                     i, vecs[i].ir, vecs[i].inta_n, cpu_if.intOut, irr, isr,
                     cpu_if.dataOut, cpu_if.dataOutEn);
            chk($sformatf("vec%0d intOut", i), {7'b0, cpu_if.intOut}, {7'b0, vecs[i].ex_int});
            chk($sformatf("vec%0d irr", i), irr, vecs[i].ex_irr);
            chk($sformatf("vec%0d isr", i), isr, vecs[i].ex_isr);
            chk($sformatf("vec%0d dataOut", i), cpu_if.dataOut, vecs[i].ex_dout);
            chk($sformatf("vec%0d dataOutEn", i), {7'b0, cpu_if.dataOutEn}, {7'b0, vecs[i].ex_den});
        end

        // EOI for IR1 in the same cycle IR1 is acknowledged: the set wins
        step(8'h00, 8'h00, 1, 1, 0, 8'h00, 0);
        step(8'h02, 8'h00, 1, 0, 0, 8'h00, 0);
        step(8'h02, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("simul intOut", {7'b0, cpu_if.intOut}, 8'h01);
        step(8'h02, 8'h00, 0, 0, 1, 8'h61, 0);
        $display("simul ack+EOI: isr=%02h", isr);
        chk("simul isr", isr, 8'h02);
        step(8'h02, 8'h00, 1, 0, 0, 8'h00, 0);
        step(8'h02, 8'h00, 0, 0, 0, 8'h00, 0);
        chk("simul dataOut", cpu_if.dataOut, 8'h41);
        chk("simul dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h01);

        // asynchronous reset while the vector is on the bus
        #2 rstN = 1'b0;
        #1;
        $display("mid-INTA reset: den=%0d isr=%02h", cpu_if.dataOutEn, isr);
        chk("async rst dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h00);
        chk("async rst isr", isr, 8'h00);
        chk("async rst dataOut", cpu_if.dataOut, 8'h00);
        rstN = 1'b1;
        step(8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("post rst dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h00);

        // INTA with nothing pending
        step(8'h00, 8'h00, 0, 0, 0, 8'h00, 0);
        chk("spur ack1 isr", isr, 8'h00);
        step(8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
        step(8'h00, 8'h00, 0, 0, 0, 8'h00, 0);
        $display("spurious ACK2: dout=%02h den=%0d isr=%02h", cpu_if.dataOut, cpu_if.dataOutEn, isr);
`ifdef PIC_SPURIOUS_IR7_EN
        chk("spur dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h01);
        chk("spur dataOut", cpu_if.dataOut, 8'h47);
`else
        chk("spur dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h00);
        chk("spur dataOut", cpu_if.dataOut, 8'h00);
`endif
        chk("spur isr", isr, 8'h00);
        step(8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("spur end dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h00);
        chk("spur end isr", isr, 8'h00);

        // level-triggered mode: IRR follows ir, acked bit reads 0 for one cycle
        ltim = 1'b1;
        step(8'h10, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("level irr", irr, 8'h10);
        step(8'h10, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("level intOut", {7'b0, cpu_if.intOut}, 8'h01);
        step(8'h10, 8'h00, 0, 0, 0, 8'h00, 0);
        chk("level ack irr", irr, 8'h00);
        chk("level ack isr", isr, 8'h10);
        step(8'h10, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("level re-irr", irr, 8'h10);
        step(8'h00, 8'h00, 0, 0, 0, 8'h00, 0);
        chk("level irr drop", irr, 8'h00);
        chk("level dataOut", cpu_if.dataOut, 8'h44);
        step(8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("level end dataOutEn", {7'b0, cpu_if.dataOutEn}, 8'h00);
        $display("level mode done: isr=%02h", isr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
